// File: rtl/lli_arbiter_rv_pkg.sv
// Shared definitions for the two-master LLI arbiter: bus widths, FSM state and
// master-selection encodings.
package lli_arbiter_rv_pkg;

    localparam int ADR_W = 30;
    localparam int DAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD_I = 2'd1,
        ST_HOLD_D = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_I    = 2'd1,
        SEL_D    = 2'd2
    } sel_t;

endpackage

// File: rtl/lli_arbiter_rv.sv
// Arbiter sharing one LLI slave between a read-only fetch master (I) and a
// data master (D), with data-phase ownership tracking and D-burst starvation limit.
module lli_arbiter_rv
    import lli_arbiter_rv_pkg::*;
#(
    parameter int MAX_D_BURST = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_re_i,
    input  logic [ADR_W-1:0] i_adr_i,
    output logic [DAT_W-1:0] i_dat_o,
    output logic             i_busy_o,
    input  logic             d_re_i,
    input  logic             d_we_i,
    input  logic [3:0]       d_sel_i,
    input  logic [ADR_W-1:0] d_adr_i,
    input  logic [DAT_W-1:0] d_dat_i,
    output logic [DAT_W-1:0] d_dat_o,
    output logic             d_busy_o,
    output logic             s_re_o,
    output logic             s_we_o,
    output logic [3:0]       s_sel_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_busy_i,
    output state_t           dbg_state,
    output logic             dbg_pend
);

    localparam logic [3:0] MAX_B = 4'(MAX_D_BURST);

    state_t           state, state_n;
    sel_t             arb, sel, pend_sel;
    logic             pend, pend_d, starve, rst_q;
    logic [3:0]       cnt, cnt_n;
    logic [ADR_W-1:0] adr_q;
    logic             i_req, d_req, accept, rd_acc;

    assign i_req    = i_re_i;
    assign d_req    = d_re_i | d_we_i;
    assign pend_sel = pend_d ? SEL_D : SEL_I;

    // Selection depends only on requests and registered state, never on s_busy_i.
    always_comb begin
        arb = SEL_NONE;
        if (d_req && !starve) arb = SEL_D;
        else if (i_req)       arb = SEL_I;
        else if (d_req)       arb = SEL_D;
        if (pend && arb != pend_sel) arb = SEL_NONE;

        sel = arb;
        case (state)
            ST_HOLD_I: sel = i_req ? SEL_I : SEL_NONE;
            ST_HOLD_D: sel = d_req ? SEL_D : SEL_NONE;
            default:   sel = arb;
        endcase
        // The cycle of and after reset issue nothing, so an abandoned request is not re-driven.
        if (rst_i || rst_q) sel = SEL_NONE;
    end

    always_comb begin
        s_re_o  = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 4'b0000;
        s_adr_o = adr_q;
        case (sel)
            SEL_I: begin
                s_re_o  = i_re_i;
                s_sel_o = 4'b1111;
                s_adr_o = i_adr_i;
            end
            SEL_D: begin
                s_re_o  = d_re_i;
                s_we_o  = d_we_i;
                s_sel_o = d_sel_i;
                s_adr_o = d_adr_i;
            end
            default: ;
        endcase
    end

    assign s_dat_o = d_dat_i;
    assign i_dat_o = s_dat_i;
    assign d_dat_o = s_dat_i;

    assign i_busy_o = (sel == SEL_I || (pend && !pend_d)) ? s_busy_i : i_req;
    assign d_busy_o = (sel == SEL_D || (pend &&  pend_d)) ? s_busy_i : d_req;

    assign accept = (sel != SEL_NONE) && (s_re_o || s_we_o) && !s_busy_i;
    assign rd_acc = accept && s_re_o;

    always_comb begin
        state_n = ST_IDLE;
        if (sel != SEL_NONE && (s_re_o || s_we_o) && s_busy_i)
            state_n = (sel == SEL_I) ? ST_HOLD_I : ST_HOLD_D;

        cnt_n = cnt;
        if (!i_re_i || (accept && sel == SEL_I)) cnt_n = 4'd0;
        else if (accept && sel == SEL_D && cnt != 4'hF) cnt_n = cnt + 4'd1;
    end

    always_ff @(posedge clk_i) begin
        rst_q <= rst_i;
        if (rst_i) begin
            state  <= ST_IDLE;
            pend   <= 1'b0;
            pend_d <= 1'b0;
            cnt    <= 4'd0;
            starve <= 1'b0;
            adr_q  <= '0;
        end else begin
            state  <= state_n;
            adr_q  <= s_adr_o;
            cnt    <= cnt_n;
            starve <= (cnt_n >= MAX_B);
            if (rd_acc) begin
                pend   <= 1'b1;
                pend_d <= (sel == SEL_D);
            end else if (!s_busy_i) begin
                pend <= 1'b0;
            end
        end
    end

    assign dbg_state = state;
    assign dbg_pend  = pend;

endmodule

// File: tb/tb_lli_arbiter_rv.sv
// Directed bench for lli_arbiter_rv: hand-computed expectations checked with
// immediate assertions at the falling clock edge.
module tb_lli_arbiter_rv;
    import lli_arbiter_rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_re;
    logic [29:0] i_adr;
    logic [31:0] i_dat;
    logic        i_busy;
    logic        d_re, d_we;
    logic [3:0]  d_sel;
    logic [29:0] d_adr;
    logic [31:0] d_dat_w, d_dat_r;
    logic        d_busy;
    logic        s_re, s_we;
    logic [3:0]  s_sel;
    logic [29:0] s_adr;
    logic [31:0] s_dat_w, s_dat_r;
    logic        s_busy;
    state_t      dbg_state;
    logic        dbg_pend;

    int total = 0;
    int bad   = 0;

    localparam logic [29:0] A1 = 30'h0000_1000, B1 = 30'h0000_2000;
    localparam logic [29:0] A2 = 30'h0000_1104, B2 = 30'h0000_2204;
    localparam logic [29:0] A3 = 30'h0000_1308, B3 = 30'h0000_2308;
    localparam logic [29:0] A4 = 30'h0000_140C, B4 = 30'h0000_240C;
    localparam logic [29:0] A5 = 30'h0000_1510;

    lli_arbiter_rv #(.MAX_D_BURST(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .i_re_i(i_re), .i_adr_i(i_adr), .i_dat_o(i_dat), .i_busy_o(i_busy),
        .d_re_i(d_re), .d_we_i(d_we), .d_sel_i(d_sel), .d_adr_i(d_adr),
        .d_dat_i(d_dat_w), .d_dat_o(d_dat_r), .d_busy_o(d_busy),
        .s_re_o(s_re), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
        .s_dat_o(s_dat_w), .s_dat_i(s_dat_r), .s_busy_i(s_busy),
        .dbg_state(dbg_state), .dbg_pend(dbg_pend)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int exp_re [6] = '{1, 1, 1, 1, 0, 1};
    int d_acc;

    initial begin
        rst = 1'b1; i_re = 0; i_adr = '0; d_re = 0; d_we = 0; d_sel = '0;
        d_adr = '0; d_dat_w = 32'h5555_AAAA; s_dat_r = '0; s_busy = 0;
        repeat (3) next_cycle();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_pend",  32'(dbg_pend), 32'd0);
        chk("rst_s_re",  32'(s_re), 32'd0);
        chk("rst_s_we",  32'(s_we), 32'd0);
        chk("rst_s_adr", 32'(s_adr), 32'd0);
        next_cycle();
        next_cycle();

        // Simultaneous first requests: D first, one bubble, then I
        d_re = 1; d_adr = A1; i_re = 1; i_adr = B1; s_busy = 0;
        @(negedge clk);
        chk("sim_c0_adr",   32'(s_adr), 32'(A1));
        chk("sim_c0_re",    32'(s_re), 32'd1);
        chk("sim_c0_ibusy", 32'(i_busy), 32'd1);
        chk("sim_c0_dbusy", 32'(d_busy), 32'd0);
        chk("sim_c0_sdat",  s_dat_w, 32'h5555_AAAA);
        next_cycle();
        d_re = 0; s_dat_r = 32'h0000_1234;
        @(negedge clk);
        chk("sim_c1_re",    32'(s_re), 32'd0);
        chk("sim_c1_adr",   32'(s_adr), 32'(A1));
        chk("sim_c1_ibusy", 32'(i_busy), 32'd1);
        chk("sim_c1_dbusy", 32'(d_busy), 32'd0);
        chk("sim_c1_ddat",  d_dat_r, 32'h0000_1234);
        next_cycle();
        @(negedge clk);
        chk("sim_c2_re",    32'(s_re), 32'd1);
        chk("sim_c2_adr",   32'(s_adr), 32'(B1));
        chk("sim_c2_ibusy", 32'(i_busy), 32'd0);
        next_cycle();
        i_re = 0; s_dat_r = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("idat_value", i_dat, 32'hDEAD_BEEF);
        chk("idat_busy",  32'(i_busy), 32'd0);
        chk("idat_pend",  32'(dbg_pend), 32'd1);
        next_cycle();
        s_dat_r = '0;
        next_cycle();

        // I read held by a busy slave while D starts requesting
        i_re = 1; i_adr = B2; s_busy = 1;
        @(negedge clk);
        chk("hold_c0_adr", 32'(s_adr), 32'(B2));
        chk("hold_c0_ibusy", 32'(i_busy), 32'd1);
        next_cycle();
        d_re = 1; d_adr = A2;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold_c%0d_adr", k),   32'(s_adr), 32'(B2));
            chk($sformatf("hold_c%0d_dbusy", k), 32'(d_busy), 32'd1);
            chk($sformatf("hold_c%0d_state", k), 32'(dbg_state), 32'(ST_HOLD_I));
            next_cycle();
        end
        s_busy = 0;
        @(negedge clk);
        chk("hold_acc_adr",   32'(s_adr), 32'(B2));
        chk("hold_acc_ibusy", 32'(i_busy), 32'd0);
        chk("hold_acc_dbusy", 32'(d_busy), 32'd1);
        next_cycle();
        i_re = 0;
        @(negedge clk);
        chk("hold_bub_re",    32'(s_re), 32'd0);
        chk("hold_bub_dbusy", 32'(d_busy), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("hold_d_adr",   32'(s_adr), 32'(A2));
        chk("hold_d_dbusy", 32'(d_busy), 32'd0);
        next_cycle();
        d_re = 0;
        next_cycle();
        next_cycle();

        // D back-to-back reads starving I: four D grants, bubble, then I
        d_re = 1; d_adr = A3; i_re = 1; i_adr = B3; d_acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("burst_c%0d_re", k), 32'(s_re), 32'(exp_re[k]));
            chk($sformatf("burst_c%0d_adr", k), 32'(s_adr), (k == 5) ? 32'(B3) : 32'(A3));
            if (s_re && !s_busy && s_adr == A3) d_acc++;
            next_cycle();
        end
        chk("burst_d_count", 32'(d_acc), 32'd4);
        d_re = 0; i_re = 0;
        next_cycle();
        next_cycle();

        // D write: no data phase, I granted right after
        d_we = 1; d_sel = 4'b0011; d_adr = A4; i_re = 1; i_adr = B4;
        @(negedge clk);
        chk("wr_we",    32'(s_we), 32'd1);
        chk("wr_re",    32'(s_re), 32'd0);
        chk("wr_sel",   32'(s_sel), 32'b0011);
        chk("wr_adr",   32'(s_adr), 32'(A4));
        chk("wr_ibusy", 32'(i_busy), 32'd1);
        next_cycle();
        d_we = 0; d_sel = '0;
        @(negedge clk);
        chk("wr_pend",   32'(dbg_pend), 32'd0);
        chk("wr_we_off", 32'(s_we), 32'd0);
        chk("wr_i_re",   32'(s_re), 32'd1);
        chk("wr_i_adr",  32'(s_adr), 32'(B4));
        next_cycle();
        i_re = 0;
        next_cycle();
        next_cycle();

        // Reset during HOLD_D abandons the transfer
        d_re = 1; d_adr = A5; s_busy = 1;
        next_cycle();
        @(negedge clk);
        chk("rsth_state", 32'(dbg_state), 32'(ST_HOLD_D));
        rst = 1;
        next_cycle();
        rst = 0;
        @(negedge clk);
        chk("rsth_re",    32'(s_re), 32'd0);
        chk("rsth_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("rsth_pend",  32'(dbg_pend), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rsth_regrant", 32'(s_re), 32'd1);
        next_cycle();
        // Held master drops its request
        d_re = 0;
        @(negedge clk);
        chk("drop_state", 32'(dbg_state), 32'(ST_HOLD_D));
        chk("drop_re",    32'(s_re), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("drop_idle", 32'(dbg_state), 32'(ST_IDLE));
        s_busy = 0;
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lli_arbiter_rv.md
LLI_ARBITER_RV -- requirements
Module: lli_arbiter_rv

Interface
REQ-001 SHALL have parameter MAX_D_BURST, default 4, meaning the maximum number of consecutive data-master acceptances while the fetch master waits (range 1..15).
REQ-002 SHALL have port clk_i, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have ports i_re_i (in, 1), i_adr_i (in, 30), i_dat_o (out, 32), i_busy_o (out, 1): fetch master, read-only LLI.
REQ-005 SHALL have ports d_re_i (in, 1), d_we_i (in, 1), d_sel_i (in, 4), d_adr_i (in, 30), d_dat_i (in, 32), d_dat_o (out, 32), d_busy_o (out, 1): data master LLI.
REQ-006 SHALL have ports s_re_o (out, 1), s_we_o (out, 1), s_sel_o (out, 4), s_adr_o (out, 30), s_dat_o (out, 32), s_dat_i (in, 32), s_busy_i (in, 1): shared slave LLI.

Function
REQ-007 SHALL follow these LLI rules: the request is accepted in a cycle with (re|we)=1 and busy=0; read data is valid in the first subsequent cycle with busy=0; the master holds the request stable while busy=1.
REQ-008 SHALL compute selection SEL (NONE, I, D) only from requests and registered state, never from s_busy_i.
REQ-009 SHALL use FSM states IDLE, HOLD_I and HOLD_D; HOLD_x is entered when master x is selected, s_re_o|s_we_o=1 and s_busy_i=1.
REQ-010 SHALL in HOLD_x force SEL=x; when the request is accepted it returns to IDLE, or re-arbitrates in the same cycle.
REQ-011 SHALL, if the held master drops its request in HOLD_x, go to IDLE next cycle, with SEL=NONE in that cycle.
REQ-012 SHALL in IDLE select as follows:
- D if d_re_i|d_we_i and the starvation flag is clear;
- else I if i_re_i;
- else D if d_re_i|d_we_i;
- else NONE.
REQ-013 SHALL hold register pend (a read accepted whose data phase is open) and register pend_src; pend sets on read acceptance and clears on a cycle with s_busy_i=0 and no new read acceptance.
REQ-014 SHALL NOT select a master different from pend_src while pend=1; the other master waits, giving one bubble per ownership change.
REQ-015 SHALL drive the s_* outputs from the selected master; with SEL=NONE, s_re_o=s_we_o=0 and s_adr_o holds its last value.
REQ-016 SHALL drive x_busy_o = s_busy_i when SEL=x or pend_src=x, else x_busy_o = (x requesting).
REQ-017 SHALL drive i_dat_o and d_dat_o both from s_dat_i unregistered, so the read latency added is zero.
REQ-018 SHALL drive s_we_o only for the data master; a write opens no data phase.
REQ-019 SHALL keep a starvation counter (4 bits):
- increments on each D acceptance while i_re_i=1;
- clears on I acceptance or when i_re_i=0;
- at MAX_D_BURST sets the starvation flag, forcing I selection on the next arbitration.
REQ-020 SHALL make simultaneous first requests from both masters in IDLE, with no starvation, go to D.

Reset
REQ-021 SHALL on rst_i=1 set FSM=IDLE, pend=0, pend_src=I, counter=0, flag=0, s_adr_o=0, and drive s_re_o=s_we_o=0 the following cycle.
REQ-022 SHALL on reset mid-operation abandon any held or pending transfer without delivering data.

Structure
REQ-023 SHALL place the FSM state encoding and the SEL encoding (2-bit typedef-equivalents) and the LLI address width 30 in the shared core package.
REQ-024 SHALL be a single module with no sub-modules; the starvation counter stays inline.

Verification
REQ-025 SHALL cover: d_re_i and i_re_i asserted together in IDLE, s_busy_i=0 -> D accepted in cycle 0 (s_adr_o=d_adr_i), I accepted in cycle 2 after 1 bubble, i_busy_o=1 in cycles 0-1.
REQ-026 SHALL cover: an I read with s_busy_i=1 for 3 cycles and d_re_i rising in cycle 1 -> s_adr_o stays i_adr_i for all 3 cycles, d_busy_o=1.
REQ-027 SHALL cover: D issuing back-to-back reads with i_re_i=1 and MAX_D_BURST=4 -> exactly 4 D acceptances, then I accepted.
REQ-028 SHALL cover: an I read with s_dat_i=32'hDEADBEEF in the data phase -> i_dat_o=32'hDEADBEEF and i_busy_o=0 in that cycle.
REQ-029 SHALL cover: a D write (d_sel_i=4'b0011) -> s_we_o=1 and s_sel_o=4'b0011 for one cycle; pend stays 0 and I is granted the next cycle.
REQ-030 SHALL cover: rst_i asserted during HOLD_D -> s_re_o=0 the next cycle and FSM=IDLE.
